tdm_frame_master: RTL and testbench

- Frame-master end of the f0/c4 serial TDM link. Generates the framing the converter consumes:
  - f0, active-low frame pulse;
  - c4, a bit clock at twice the bit rate.
- Serializes a parallel word from the STM-side logic onto data_to_dt, MSB first.
- Deserializes the returning data_from_dt into a parallel word and flags it via cpu_int.
- Serves as the bench/board-side counterpart for driving a converter-style slave.

---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_bit_timer.sv | 68 ++++++
 rtl/tdm_frame_master.sv | 164 ++++++++++++++++
 tb/tb_tdm_frame_master.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the f0/c4 TDM frame master.
package tdm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } tdm_state_e;

  localparam int TDM_CLK_DIV    = 2;
  localparam int TDM_FRAME_BITS = 32;
  localparam int TDM_MAX_BITS   = 64;

  // Shifted out when a frame starts with no word loaded.
  localparam logic [TDM_MAX_BITS-1:0] TDM_IDLE_FILL = '1;

endpackage

// File: rtl/tdm_bit_timer.sv
// Per-bit phase counter, frame bit index and registered c4; everything parks at phase 0 while run is low.
// Strobes are one clk wide, asserted in the clk whose closing edge starts a bit / the second half / the sample.
module tdm_bit_timer #(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic count_bits,
  output logic c4,
  output logic bit_start,
  output logic half_strobe,
  output logic sample_strobe,
  output logic last_bit
);

  localparam int PH_W = (4 * CLK_DIV > 2) ? $clog2(4 * CLK_DIV) : 1;
  localparam int BI_W = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;

  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(4 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(3 * CLK_DIV);
  localparam logic [PH_W-1:0] PH_C4_A   = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] PH_C4_B   = PH_W'(2 * CLK_DIV);
  localparam logic [PH_W-1:0] PH_C4_C   = PH_W'(3 * CLK_DIV);
  localparam logic [BI_W-1:0] BIT_LAST  = BI_W'(FRAME_BITS - 1);

  logic [PH_W-1:0] ph_q, ph_d;
  logic [BI_W-1:0] bit_q, bit_d;
  logic            c4_q, c4_d;

  always_comb begin
    ph_d  = '0;
    bit_d = '0;
    if (run) begin
      ph_d  = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
      bit_d = bit_q;
      if (ph_q == PH_LAST && count_bits) begin
        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
      end
    end
  end

  // c4 is decoded from the next phase so the flop lines up with ph_q.
  always_comb begin
    c4_d = ((ph_d >= PH_C4_A) && (ph_d < PH_C4_B)) || (ph_d >= PH_C4_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q  <= '0;
      bit_q <= '0;
      c4_q  <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      bit_q <= bit_d;
      c4_q  <= c4_d;
    end
  end

  assign c4            = c4_q;
  assign bit_start     = run && (ph_q == PH_LAST);
  assign half_strobe   = run && (ph_q == PH_HALF);
  assign sample_strobe = run && (ph_q == PH_SAMPLE);
  assign last_bit      = (bit_q == BIT_LAST);

endmodule

// File: rtl/tdm_frame_master.sv
// f0/c4 TDM frame master: SYNC bit then back-to-back frames, MSB-first tx/rx, one-entry tx buffer (tx_ready = empty).
// Define TDM_LOOPBACK_EN to add the loopback input that feeds data_to_dt back into the receive sampler.
module tdm_frame_master
  import tdm_pkg::*;
#(
  parameter int CLK_DIV    = TDM_CLK_DIV,
  parameter int FRAME_BITS = TDM_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [FRAME_BITS-1:0] tx_word,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  f0,
  output logic                  c4,
  output logic                  data_to_dt,
  input  logic                  data_from_dt,
`ifdef TDM_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic [FRAME_BITS-1:0] rx_word,
  output logic                  rx_valid,
  output logic                  cpu_int,
  input  logic                  int_ack,
  output logic                  underrun
);

  tdm_state_e            state_q;
  logic [FRAME_BITS-1:0] buf_q, tx_sr_q, rx_sr_q, rx_word_q;
  logic                  buf_vld_q, f0_q, dout_q, cont_q;
  logic                  rx_valid_q, cpu_int_q, underrun_q;

  logic                  bit_start, half_strobe, sample_strobe, last_bit;
  logic                  rx_bit, load_now, load_empty;
  logic [FRAME_BITS-1:0] rx_next, tx_load;

  tdm_bit_timer #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .run           (state_q != IDLE),
    .count_bits    (state_q == RUN),
    .c4            (c4),
    .bit_start     (bit_start),
    .half_strobe   (half_strobe),
    .sample_strobe (sample_strobe),
    .last_bit      (last_bit)
  );

`ifdef TDM_LOOPBACK_EN
  assign rx_bit = loopback ? dout_q : data_from_dt;
`else
  assign rx_bit = data_from_dt;
`endif

  assign rx_next  = {rx_sr_q[FRAME_BITS-2:0], rx_bit};
  assign load_now = bit_start &&
                    ((state_q == SYNC) || (state_q == RUN && last_bit && cont_q));

  // A word offered in the very clk the buffer is drained goes straight to the shifter.
  always_comb begin
    load_empty = 1'b0;
    if (buf_vld_q) begin
      tx_load = buf_q;
    end else if (tx_valid) begin
      tx_load = tx_word;
    end else begin
      tx_load    = FRAME_BITS'(TDM_IDLE_FILL);
      load_empty = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_word_q  <= '0;
      f0_q       <= 1'b1;
      dout_q     <= 1'b1;
      cont_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      cpu_int_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      cpu_int_q  <= rx_valid_q | (cpu_int_q & ~int_ack);

      if (load_now) begin
        buf_vld_q <= 1'b0;
        tx_sr_q   <= {tx_load[FRAME_BITS-2:0], 1'b1};
        dout_q    <= tx_load[FRAME_BITS-1];
        if (load_empty) begin
          underrun_q <= 1'b1;
        end
      end else if (tx_valid && !buf_vld_q) begin
        buf_q     <= tx_word;
        buf_vld_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          f0_q   <= 1'b1;
          dout_q <= 1'b1;
          cont_q <= 1'b0;
          if (enable) begin
            state_q <= SYNC;
          end
        end
        SYNC: begin
          if (half_strobe) begin
            f0_q <= 1'b0;
          end
          if (bit_start) begin
            f0_q    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (sample_strobe) begin
            rx_sr_q <= rx_next;
            if (last_bit) begin
              rx_word_q  <= rx_next;
              rx_valid_q <= 1'b1;
            end
          end
          // enable is judged once, at the half of the last bit, so f0 and the next frame agree.
          if (half_strobe && last_bit) begin
            cont_q <= enable;
            f0_q   <= ~enable;
          end
          if (bit_start) begin
            f0_q   <= 1'b1;
            cont_q <= 1'b0;
            if (!last_bit) begin
              dout_q  <= tx_sr_q[FRAME_BITS-1];
              tx_sr_q <= tx_sr_q << 1;
            end else if (!cont_q) begin
              state_q <= IDLE;
              dout_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready   = ~buf_vld_q;
  assign f0         = f0_q;
  assign data_to_dt = dout_q;
  assign rx_word    = rx_word_q;
  assign rx_valid   = rx_valid_q;
  assign cpu_int    = cpu_int_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_tdm_frame_master.sv
// Scoreboard bench for tdm_frame_master at CLK_DIV=2, FRAME_BITS=32 (8 clk per bit).
module tb_tdm_frame_master;

  localparam int FB = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          tx_valid = 1'b0;
  logic          data_from_dt = 1'b1;
  logic          int_ack = 1'b0;
  logic [FB-1:0] tx_word = '0;
  logic          tx_ready, f0, c4, data_to_dt, rx_valid, cpu_int, underrun;
  logic [FB-1:0] rx_word;
`ifdef TDM_LOOPBACK_EN
  logic          loopback = 1'b0;
`endif

  int            checks = 0;
  int            failures = 0;
  logic [FB-1:0] tx_exp_q[$];
  logic [FB-1:0] rx_exp_q[$];

  always #5 clk = ~clk;

  tdm_frame_master #(
    .CLK_DIV    (2),
    .FRAME_BITS (FB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tx_word      (tx_word),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .f0           (f0),
    .c4           (c4),
    .data_to_dt   (data_to_dt),
    .data_from_dt (data_from_dt),
`ifdef TDM_LOOPBACK_EN
    .loopback     (loopback),
`endif
    .rx_word      (rx_word),
    .rx_valid     (rx_valid),
    .cpu_int      (cpu_int),
    .int_ack      (int_ack),
    .underrun     (underrun)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [FB-1:0] w);
    chk("tx_ready_before_load", 64'(tx_ready), 64'd1);
    tx_word  = w;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("tx_ready_after_load", 64'(tx_ready), 64'd0);
    tx_exp_q.push_back(w);
  endtask

  // Entered in the first SYNC clk; leaves at phase 0 of bit 0.
  task automatic sync_phase();
    logic [7:0] f0v, c4v, dv;
    for (int i = 0; i < 8; i++) begin
      f0v[i] = f0;
      c4v[i] = c4;
      dv[i]  = data_to_dt;
      tick();
    end
    chk("sync_f0", 64'(f0v), 64'h0F);
    chk("sync_c4", 64'(c4v), 64'hCC);
    chk("sync_dout", 64'(dv), 64'hFF);
  endtask

  // Entered at phase 0 of bit 0; leaves at phase 0 of the following bit period.
  task automatic run_frame(input logic [FB-1:0] rx_drive, input int drop_bit, input int load_bit,
                           input logic [FB-1:0] load_word, input bit ack_last, input bit ack_clr_first,
                           input logic exp_underrun, input int abort_bit);
    logic [FB-1:0] txa, txb, exp_tx;
    logic [7:0]    c4v, f0v, f0_exp;
    logic          f0_mid;
    txa = '0; txb = '0; c4v = '0; f0v = '0; f0_exp = 8'h0F; f0_mid = 1'b1;
    for (int b = 0; b < FB; b++) begin
      for (int p = 0; p < 8; p++) begin
        if (p == 0) begin
          data_from_dt = rx_drive[FB-1-b];
          if (b == drop_bit) enable = 1'b0;
          if (b == FB-1) f0_exp = enable ? 8'h0F : 8'hFF;
        end
        if (b == 0 && p == 1) begin
          chk("tx_ready_frame_start", 64'(tx_ready), 64'd1);
          chk("underrun", 64'(underrun), 64'(exp_underrun));
          if (ack_clr_first) begin
            chk("int_ack_clears", 64'(cpu_int), 64'd0);
            int_ack = 1'b0;
          end
        end
        if (b == load_bit && p == 2) begin
          chk("tx_ready_in_frame", 64'(tx_ready), 64'd1);
          tx_word  = load_word;
          tx_valid = 1'b1;
        end
        if (b == load_bit && p == 3) begin
          tx_valid = 1'b0;
          chk("tx_ready_held", 64'(tx_ready), 64'd0);
          tx_exp_q.push_back(load_word);
        end
        if (b == abort_bit && p == 3) begin
          reset = 1'b1;
          #1;
          chk("rst_f0", 64'(f0), 64'd1);
          chk("rst_c4", 64'(c4), 64'd0);
          chk("rst_dout", 64'(data_to_dt), 64'd1);
          chk("rst_tx_ready", 64'(tx_ready), 64'd1);
          chk("rst_rx_word", 64'(rx_word), 64'd0);
          chk("rst_rx_valid", 64'(rx_valid), 64'd0);
          chk("rst_cpu_int", 64'(cpu_int), 64'd0);
          chk("rst_underrun", 64'(underrun), 64'd0);
          tx_exp_q.delete();
          rx_exp_q.delete();
          enable = 1'b0;
          return;
        end
        if (b == 0) c4v[p] = c4;
        if (b == FB-1) f0v[p] = f0;
        else f0_mid = f0_mid & f0;
        if (p == 1) txa[FB-1-b] = data_to_dt;
        if (p == 7) txb[FB-1-b] = data_to_dt;
        if (b == FB-1 && p == 6) chk("rx_valid_early", 64'(rx_valid), 64'd0);
        if (b == FB-1 && p == 7) begin
          chk("rx_valid_pulse", 64'(rx_valid), 64'd1);
          if (ack_last) int_ack = 1'b1;
        end
        tick();
      end
    end
    chk("bit0_c4", 64'(c4v), 64'hCC);
    chk("f0_mid_frame", 64'(f0_mid), 64'd1);
    chk("f0_last_bit", 64'(f0v), 64'(f0_exp));
    chk("tx_queue_nonempty", 64'(tx_exp_q.size() != 0), 64'd1);
    if (tx_exp_q.size() != 0) begin
      exp_tx = tx_exp_q.pop_front();
      chk("tx_serial", 64'(txa), 64'(exp_tx));
      chk("tx_hold", 64'(txb), 64'(exp_tx));
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rx_valid) begin
      chk("rx_expected", 64'(rx_exp_q.size() != 0), 64'd1);
      if (rx_exp_q.size() != 0) chk("rx_word", 64'(rx_word), 64'(rx_exp_q.pop_front()));
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          c4_any, f0_all, d_all;
    logic [FB-1:0] last_drive;

    repeat (3) tick();
    chk("reset_f0", 64'(f0), 64'd1);
    chk("reset_c4", 64'(c4), 64'd0);
    chk("reset_dout", 64'(data_to_dt), 64'd1);
    chk("reset_tx_ready", 64'(tx_ready), 64'd1);
    chk("reset_rx_word", 64'(rx_word), 64'd0);
    chk("reset_rx_valid", 64'(rx_valid), 64'd0);
    chk("reset_cpu_int", 64'(cpu_int), 64'd0);
    chk("reset_underrun", 64'(underrun), 64'd0);
    reset = 1'b0;
    tick();

    // Frame 1: loaded word, slave returns 0x12345678.
    load(32'hA5C3_0F81);
    enable = 1'b1;
    tick();
    sync_phase();
    rx_exp_q.push_back(32'h1234_5678);
    run_frame(32'h1234_5678, -1, -1, '0, 1'b0, 1'b0, 1'b0, -1);
    chk("cpu_int_set", 64'(cpu_int), 64'd1);

    // Frame 2: nothing loaded -> all ones and underrun; next word loaded mid-frame; ack on the rx_valid clk.
    tx_exp_q.push_back(32'hFFFF_FFFF);
    rx_exp_q.push_back(32'hCAFE_0001);
    run_frame(32'hCAFE_0001, -1, 4, 32'h0F0F_3C3C, 1'b1, 1'b0, 1'b1, -1);
    chk("int_set_wins", 64'(cpu_int), 64'd1);

    // Frame 3: ack held one more clk clears; enable dropped at bit 10.
    rx_exp_q.push_back(32'h8000_0001);
    run_frame(32'h8000_0001, 10, -1, '0, 1'b0, 1'b1, 1'b1, -1);
    c4_any = 1'b0; f0_all = 1'b1; d_all = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c4_any = c4_any | c4;
      f0_all = f0_all & f0;
      d_all  = d_all & data_to_dt;
      tick();
    end
    chk("idle_c4_low", 64'(c4_any), 64'd0);
    chk("idle_f0_high", 64'(f0_all), 64'd1);
    chk("idle_dout_high", 64'(d_all), 64'd1);
    chk("underrun_sticky", 64'(underrun), 64'd1);
    chk("cpu_int_after_f3", 64'(cpu_int), 64'd1);
    chk("rx_all_seen_f3", 64'(rx_exp_q.size()), 64'd0);

    // Frame 4: reset asserted at bit 15 with a word pending.
    load(32'h0000_0000);
    enable = 1'b1;
    tick();
    sync_phase();
    run_frame(32'hFFFF_0000, -1, 4, 32'h1111_2222, 1'b0, 1'b0, 1'b1, 15);
    repeat (3) tick();
    reset = 1'b0;
    repeat (300) tick();
    chk("no_rx_after_abort", 64'(rx_word), 64'd0);

    // Frame 5: restart after reset; loopback build receives its own transmit word.
`ifdef TDM_LOOPBACK_EN
    loopback   = 1'b1;
    last_drive = 32'hFFFF_0000;
`else
    last_drive = 32'h0000_FFFF;
`endif
    load(32'h0000_FFFF);
    enable = 1'b1;
    tick();
    sync_phase();
    rx_exp_q.push_back(32'h0000_FFFF);
    run_frame(last_drive, 0, -1, '0, 1'b0, 1'b0, 1'b0, -1);
    repeat (4) tick();
    chk("rx_all_seen_f5", 64'(rx_exp_q.size()), 64'd0);
    chk("final_c4_low", 64'(c4), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
